rect_row_scheduler: RTL and testbench

//  Sequences the frame-buffer addressing datapath for one rectangle draw command at a time.
//  - Accepts origin/size from the decode engine and clips the rectangle to the screen.
//  - Walks the rectangle row by row.
//  - Per row, issues the packed start address (8 px per 3 bytes) to the generation engine

---
 rtl/rect_row_scheduler_pkg.sv | 22 ++
 rtl/rect_row_scheduler_if.sv | 34 +++
 rtl/rect_row_scheduler_row_addr_calc.sv | 50 +++++
 rtl/rect_row_scheduler.sv | 153 +++++++++++++++
 tb/tb_rect_row_scheduler.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rect_row_scheduler_pkg.sv
// Shared constants and FSM state encoding for the rectangle row scheduler.
// Screen defaults, pixel packing (8 pixels in 3 bytes) and the 4-bit state type.
package rect_row_scheduler_pkg;

  localparam int SCREEN_W_DEF  = 640;
  localparam int SCREEN_H_DEF  = 480;
  localparam int ADDR_W_DEF    = 17;
  localparam int DIM_W         = 16;
  localparam int PIX_PER_GRP   = 8;
  localparam int BYTES_PER_GRP = 3;
  localparam int GRP_SHIFT     = $clog2(PIX_PER_GRP);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_CLIP     = 4'd1,
    ST_ROW_BASE = 4'd2,
    ST_ROW_ADDR = 4'd3,
    ST_ISSUE    = 4'd4,
    ST_DONE     = 4'd5
  } state_t;

endpackage

// File: rtl/rect_row_scheduler_if.sv
// Command and row-descriptor bundle between decode engine, scheduler and generation engine.
// The scheduler takes the slave modport; the surrounding engines take master.
interface rect_row_scheduler_if #(
  parameter int ADDR_W = rect_row_scheduler_pkg::ADDR_W_DEF
);
  import rect_row_scheduler_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [DIM_W-1:0]     cmd_origx;
  logic [DIM_W-1:0]     cmd_origy;
  logic [DIM_W-1:0]     cmd_width;
  logic [DIM_W-1:0]     cmd_height;
  logic                 abort;
  logic                 row_valid;
  logic                 row_ready;
  logic [ADDR_W-1:0]    row_addr;
  logic [GRP_SHIFT-1:0] row_bit_ofs;
  logic [DIM_W-1:0]     row_len;
  logic                 row_last;
  logic                 busy;
  logic                 done_strobe;

  modport slave (
    input  cmd_valid, cmd_origx, cmd_origy, cmd_width, cmd_height, abort, row_ready,
    output cmd_ready, row_valid, row_addr, row_bit_ofs, row_len, row_last, busy, done_strobe
  );

  modport master (
    output cmd_valid, cmd_origx, cmd_origy, cmd_width, cmd_height, abort, row_ready,
    input  cmd_ready, row_valid, row_addr, row_bit_ofs, row_len, row_last, busy, done_strobe
  );

endinterface

// File: rtl/rect_row_scheduler_row_addr_calc.sv
// Two-stage registered path: (row, column) -> linear pixel index -> packed byte address.
// Each stage advances only on its enable; there is no handshake.
module row_addr_calc
  import rect_row_scheduler_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ROW_W    = $clog2(SCREEN_H),
  parameter int COL_W    = $clog2(SCREEN_W)
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic                 base_en,
  input  logic                 addr_en,
  input  logic [ROW_W-1:0]     row,
  input  logic [COL_W-1:0]     col,
  output logic [ADDR_W-1:0]    row_addr,
  output logic [GRP_SHIFT-1:0] row_bit_ofs
);

  localparam int PIX_W  = $clog2(SCREEN_W * SCREEN_H);
  localparam int GRP_W  = PIX_W - GRP_SHIFT;
  localparam int PROD_W = GRP_W + 2;

  logic [PIX_W-1:0]  pix_idx;
  logic [PROD_W-1:0] packed_addr;

  // Group index times bytes-per-group, widened so the product cannot overflow.
  always_comb begin
    packed_addr = PROD_W'(pix_idx[PIX_W-1:GRP_SHIFT]) * PROD_W'(BYTES_PER_GRP);
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      pix_idx     <= '0;
      row_addr    <= '0;
      row_bit_ofs <= '0;
    end else begin
      if (base_en) begin
        pix_idx <= PIX_W'(row) * PIX_W'(SCREEN_W) + PIX_W'(col);
      end
      if (addr_en) begin
        row_addr    <= ADDR_W'(packed_addr);
        row_bit_ofs <= pix_idx[GRP_SHIFT-1:0];
      end
    end
  end

endmodule

// File: rtl/rect_row_scheduler.sv
// Clips one rectangle command to the screen and issues one packed start address per row
// to the generation engine over a valid/ready handshake.
module rect_row_scheduler
  import rect_row_scheduler_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                rst_,
  rect_row_scheduler_if.slave bus
);

  localparam int ROW_W = $clog2(SCREEN_H);
  localparam int COL_W = $clog2(SCREEN_W);
  localparam int EXT_W = DIM_W + 1;

  state_t state, next_state;

  logic [DIM_W-1:0] x_q, y_q, w_q, h_q;
  logic [DIM_W-1:0] wc, rows_left;
  logic [DIM_W-1:0] clip_w, clip_h;
  logic [EXT_W-1:0] room_w, room_h;
  logic [ROW_W-1:0] row;
  logic             offscreen;
  logic             accept, clip_load, base_en, addr_en, row_take;

  // Comparisons are one bit wider than the operands so an off-screen origin never wraps.
  always_comb begin
    offscreen = ({1'b0, x_q} >= EXT_W'(SCREEN_W)) || ({1'b0, y_q} >= EXT_W'(SCREEN_H));
    room_w    = EXT_W'(SCREEN_W) - {1'b0, x_q};
    room_h    = EXT_W'(SCREEN_H) - {1'b0, y_q};
    clip_w    = ({1'b0, w_q} < room_w) ? w_q : room_w[DIM_W-1:0];
    clip_h    = ({1'b0, h_q} < room_h) ? h_q : room_h[DIM_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state      = state;
    accept          = 1'b0;
    clip_load       = 1'b0;
    base_en         = 1'b0;
    addr_en         = 1'b0;
    row_take        = 1'b0;
    bus.cmd_ready   = (state == ST_IDLE) && !rst_;
    bus.row_valid   = (state == ST_ISSUE);
    bus.busy        = (state != ST_IDLE);
    bus.done_strobe = (state == ST_DONE) && !rst_;

    // Abort wins over everything, including a row handshake in the same cycle.
    if (bus.abort && state != ST_IDLE) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            accept     = 1'b1;
            next_state = ST_CLIP;
          end
        end
        ST_CLIP: begin
          if (offscreen || clip_w == '0 || clip_h == '0) begin
            next_state = ST_DONE;
          end else begin
            clip_load  = 1'b1;
            next_state = ST_ROW_BASE;
          end
        end
        ST_ROW_BASE: begin
          base_en    = 1'b1;
          next_state = ST_ROW_ADDR;
        end
        ST_ROW_ADDR: begin
          addr_en    = 1'b1;
          next_state = ST_ISSUE;
        end
        ST_ISSUE: begin
          if (bus.row_ready) begin
            row_take   = 1'b1;
            next_state = bus.row_last ? ST_DONE : ST_ROW_BASE;
          end
        end
        ST_DONE: begin
          next_state = ST_IDLE;
        end
        default: begin
          next_state = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      x_q          <= '0;
      y_q          <= '0;
      w_q          <= '0;
      h_q          <= '0;
      wc           <= '0;
      rows_left    <= '0;
      row          <= '0;
      bus.row_len  <= '0;
      bus.row_last <= 1'b0;
    end else begin
      if (accept) begin
        x_q <= bus.cmd_origx;
        y_q <= bus.cmd_origy;
        w_q <= bus.cmd_width;
        h_q <= bus.cmd_height;
      end
      // y is known to be on-screen here, so its low bits hold the whole row number.
      if (clip_load) begin
        wc        <= clip_w;
        rows_left <= clip_h;
        row       <= y_q[ROW_W-1:0];
      end
      if (addr_en) begin
        bus.row_len  <= wc;
        bus.row_last <= (rows_left == DIM_W'(1));
      end
      if (row_take && !bus.row_last) begin
        row       <= row + ROW_W'(1);
        rows_left <= rows_left - DIM_W'(1);
      end
    end
  end

  row_addr_calc #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .ADDR_W   (ADDR_W),
    .ROW_W    (ROW_W),
    .COL_W    (COL_W)
  ) u_row_addr_calc (
    .clk         (clk),
    .rst_        (rst_),
    .base_en     (base_en),
    .addr_en     (addr_en),
    .row         (row),
    .col         (x_q[COL_W-1:0]),
    .row_addr    (bus.row_addr),
    .row_bit_ofs (bus.row_bit_ofs)
  );

endmodule

// File: tb/tb_rect_row_scheduler.sv
// Scoreboard bench for rect_row_scheduler: stimulus queues expected rows and done pulses
// with their cycle stamps; a negedge monitor pops and compares whenever the DUT presents them.
module tb_rect_row_scheduler;

  typedef struct {
    int addr;
    int ofs;
    int len;
    int last;
    int cyc;
  } row_exp_t;

  logic clk;
  logic rst_;
  int   cyc;
  int   errors;
  int   checks;

  row_exp_t row_q[$];
  int       done_q[$];

  logic        stall_prev;
  logic [16:0] prev_addr;
  logic [2:0]  prev_ofs;
  logic [15:0] prev_len;
  logic        prev_last;

  rect_row_scheduler_if #(.ADDR_W(17)) bus ();

  rect_row_scheduler #(
    .SCREEN_W (640),
    .SCREEN_H (480),
    .ADDR_W   (17)
  ) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every taken row, every done pulse, and holds during stalls.
  always @(negedge clk) begin
    row_exp_t e;
    if (!rst_ && !bus.abort && bus.row_valid && bus.row_ready) begin
      checks++;
      if (row_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL row_unexpected: got addr=%0d ofs=%0d len=%0d last=%0d cyc=%0d, required no row",
                 bus.row_addr, bus.row_bit_ofs, bus.row_len, bus.row_last, cyc);
      end else begin
        e = row_q.pop_front();
        if (int'(bus.row_addr) != e.addr || int'(bus.row_bit_ofs) != e.ofs ||
            int'(bus.row_len) != e.len || int'(bus.row_last) != e.last || cyc != e.cyc) begin
          errors++;
          $display("[TB] FAIL row: got addr=%0d ofs=%0d len=%0d last=%0d cyc=%0d, required addr=%0d ofs=%0d len=%0d last=%0d cyc=%0d",
                   bus.row_addr, bus.row_bit_ofs, bus.row_len, bus.row_last, cyc,
                   e.addr, e.ofs, e.len, e.last, e.cyc);
        end
      end
    end
    if (bus.done_strobe) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL done_unexpected: got done_strobe at cyc=%0d, required none", cyc);
      end else if (done_q[0] != cyc) begin
        errors++;
        $display("[TB] FAIL done_time: got cyc=%0d, required cyc=%0d", cyc, done_q[0]);
        void'(done_q.pop_front());
      end else begin
        void'(done_q.pop_front());
      end
    end
    if (stall_prev) begin
      checks++;
      if (!bus.row_valid || bus.row_addr != prev_addr || bus.row_bit_ofs != prev_ofs ||
          bus.row_len != prev_len || bus.row_last != prev_last) begin
        errors++;
        $display("[TB] FAIL stall_hold: got valid=%0d addr=%0d ofs=%0d len=%0d last=%0d, required valid=1 addr=%0d ofs=%0d len=%0d last=%0d",
                 bus.row_valid, bus.row_addr, bus.row_bit_ofs, bus.row_len, bus.row_last,
                 prev_addr, prev_ofs, prev_len, prev_last);
      end
    end
    stall_prev = !rst_ && !bus.abort && bus.row_valid && !bus.row_ready;
    prev_addr  = bus.row_addr;
    prev_ofs   = bus.row_bit_ofs;
    prev_len   = bus.row_len;
    prev_last  = bus.row_last;
  end

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push_row(input int addr, input int ofs, input int len, input int last, input int c);
    row_exp_t e;
    e.addr = addr;
    e.ofs  = ofs;
    e.len  = len;
    e.last = last;
    e.cyc  = c;
    row_q.push_back(e);
  endtask

  // Offers a command once cmd_ready is seen; returns the cycle count of the accepting edge.
  task automatic apply_stimulus(input int x, input int y, input int w, input int h, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_output("cmd_ready_wait", int'(bus.cmd_ready), 1);
    bus.cmd_origx  = 16'(x);
    bus.cmd_origy  = 16'(y);
    bus.cmd_width  = 16'(w);
    bus.cmd_height = 16'(h);
    bus.cmd_valid  = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((bus.busy || row_q.size() != 0 || done_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.busy || row_q.size() != 0 || done_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_drain: got busy=%0d rows_pending=%0d dones_pending=%0d, required all 0",
               name, bus.busy, row_q.size(), done_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish by 200000, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a, b, c;
    cyc            = 0;
    errors         = 0;
    checks         = 0;
    stall_prev     = 1'b0;
    rst_           = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_origx  = '0;
    bus.cmd_origy  = '0;
    bus.cmd_width  = '0;
    bus.cmd_height = '0;
    bus.abort      = 1'b0;
    bus.row_ready  = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_cmd_ready", int'(bus.cmd_ready), 0);
    check_output("rst_busy", int'(bus.busy), 0);
    check_output("rst_row_valid", int'(bus.row_valid), 0);
    @(posedge clk);
    #1;
    rst_ = 1'b0;
    @(negedge clk);
    check_output("idle_cmd_ready", int'(bus.cmd_ready), 1);
    check_output("idle_row_addr", int'(bus.row_addr), 0);
    check_output("idle_row_len", int'(bus.row_len), 0);
    check_output("idle_done", int'(bus.done_strobe), 0);

    $display("[TB] single 8-pixel row at origin");
    apply_stimulus(0, 0, 8, 1, a);
    push_row(0, 0, 8, 1, a + 3);
    done_q.push_back(a + 4);
    wait_idle("t1");

    $display("[TB] three rows at x=13 y=2");
    apply_stimulus(13, 2, 20, 3, a);
    push_row(483, 5, 20, 0, a + 3);
    push_row(723, 5, 20, 0, a + 6);
    push_row(963, 5, 20, 1, a + 9);
    done_q.push_back(a + 10);
    wait_idle("t2");

    $display("[TB] bottom-right corner clipping");
    apply_stimulus(630, 478, 50, 10, a);
    push_row(114954, 6, 10, 0, a + 3);
    push_row(115194, 6, 10, 1, a + 6);
    done_q.push_back(a + 7);
    wait_idle("t3");

    $display("[TB] back-pressure on the second row");
    apply_stimulus(13, 2, 20, 3, a);
    push_row(483, 5, 20, 0, a + 3);
    push_row(723, 5, 20, 0, a + 11);
    push_row(963, 5, 20, 1, a + 14);
    done_q.push_back(a + 15);
    wait_until(a + 4);
    bus.row_ready = 1'b0;
    wait_until(a + 11);
    bus.row_ready = 1'b1;
    wait_idle("t4");

    $display("[TB] empty commands");
    apply_stimulus(640, 0, 4, 4, a);
    done_q.push_back(a + 1);
    apply_stimulus(0, 0, 4, 0, b);
    done_q.push_back(b + 1);
    check_output("empty_next_accept", b, a + 3);
    apply_stimulus(0, 0, 8, 1, c);
    check_output("empty_next_accept2", c, b + 3);
    push_row(0, 0, 8, 1, c + 3);
    done_q.push_back(c + 4);
    wait_idle("t5");

    $display("[TB] abort in ISSUE then reset mid-command");
    apply_stimulus(13, 2, 20, 3, a);
    push_row(483, 5, 20, 0, a + 3);
    wait_until(a + 6);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    @(negedge clk);
    check_output("abort_row_valid", int'(bus.row_valid), 0);
    check_output("abort_busy", int'(bus.busy), 0);
    bus.abort = 1'b1;
    apply_stimulus(0, 0, 8, 1, b);
    bus.abort = 1'b0;
    @(posedge clk);
    #1;
    rst_ = 1'b1;
    @(negedge clk);
    check_output("midrst_cmd_ready", int'(bus.cmd_ready), 0);
    @(posedge clk);
    #1;
    rst_ = 1'b0;
    @(negedge clk);
    check_output("post_rst_cmd_ready", int'(bus.cmd_ready), 1);
    check_output("post_rst_busy", int'(bus.busy), 0);
    check_output("post_rst_row_valid", int'(bus.row_valid), 0);
    check_output("post_rst_row_addr", int'(bus.row_addr), 0);
    check_output("post_rst_row_ofs", int'(bus.row_bit_ofs), 0);
    check_output("post_rst_row_len", int'(bus.row_len), 0);
    check_output("post_rst_row_last", int'(bus.row_last), 0);
    repeat (10) @(negedge clk);
    check_output("final_rows_pending", row_q.size(), 0);
    check_output("final_dones_pending", done_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
